// File: rtl/tick_rate_controller.sv
// Programmable square-wave divider with a glitch-free half-period update path.
// A new half-period offered while running is held in a pending register.
// It takes effect only at the end of a complete output period (a falling-edge wrap),
// so no output period is ever cut short or stretched.
module tick_rate_controller #(
    parameter int          DIV_W        = 27,
    parameter int unsigned DEFAULT_HALF = 50000000
) (
    input  logic             clk_in,
    input  logic             resetf,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] cur_half
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] counter;
    logic [DIV_W-1:0] pend_half;

    logic cfg_accept;
    logic cfg_zero;
    logic cfg_ok;
    logic wrap;
    logic period_end;

    assign cfg_accept = cfg_valid && cfg_ready;
    assign cfg_zero   = (cfg_half == '0);
    assign cfg_ok     = cfg_accept && !cfg_zero;
    assign wrap       = (counter == (cur_half - DIV_W'(1)));
    // A wrap while high ends a full output period: the only safe switch point.
    assign period_end = wrap && clk_out;

    // Control FSM, divider counter and all registered outputs.
    always_ff @(posedge clk_in or posedge resetf) begin
        if (resetf) begin
            state     <= S_IDLE;
            counter   <= '0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b1;
            cur_half  <= DIV_W'(DEFAULT_HALF);
        end else begin
            cfg_err <= cfg_accept && cfg_zero;
            tick    <= 1'b0;
            case (state)
                S_IDLE: begin
                    counter <= '0;
                    clk_out <= 1'b0;
                    if (cfg_ok) begin
                        cur_half <= cfg_half;
                    end
                    if (enable) begin
                        state <= S_RUN;
                    end
                    cfg_ready <= 1'b1;
                end
                S_RUN: begin
                    if (!enable) begin
                        // Stopping: a config offered in the same cycle applies directly.
                        counter   <= '0;
                        clk_out   <= 1'b0;
                        state     <= S_IDLE;
                        cfg_ready <= 1'b1;
                        if (cfg_ok) begin
                            cur_half <= cfg_half;
                        end
                    end else begin
                        if (wrap) begin
                            counter <= '0;
                            clk_out <= !clk_out;
                            tick    <= !clk_out;
                        end else begin
                            counter <= counter + DIV_W'(1);
                        end
                        if (cfg_ok) begin
                            state     <= S_PEND;
                            cfg_ready <= 1'b0;
                        end else begin
                            cfg_ready <= 1'b1;
                        end
                    end
                end
                S_PEND: begin
                    if (!enable) begin
                        cur_half  <= pend_half;
                        counter   <= '0;
                        clk_out   <= 1'b0;
                        state     <= S_IDLE;
                        cfg_ready <= 1'b1;
                    end else if (period_end) begin
                        cur_half  <= pend_half;
                        counter   <= '0;
                        clk_out   <= 1'b0;
                        state     <= S_RUN;
                        cfg_ready <= 1'b1;
                    end else begin
                        if (wrap) begin
                            counter <= '0;
                            clk_out <= !clk_out;
                            tick    <= !clk_out;
                        end else begin
                            counter <= counter + DIV_W'(1);
                        end
                        cfg_ready <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    counter   <= '0;
                    clk_out   <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    // Pending half-period capture.
    // It is only consumed from PEND, which reset always leaves.
    always_ff @(posedge clk_in) begin
        if ((state == S_RUN) && enable && cfg_ok) begin
            pend_half <= cfg_half;
        end
    end

endmodule

// File: tb/tick_rate_controller_tb.sv
// Testbench for tick_rate_controller.
// A cycle-by-cycle vector table covers the main flow.
// Hand-written sequences cover PEND with enable dropped and asynchronous reset.
module tb_tick_rate_controller;

    localparam int DIV_W = 8;

    logic             clk_in;
    logic             resetf;
    logic             enable;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;
    logic [DIV_W-1:0] cur_half;

    int total;
    int bad;

    typedef struct {
        logic       en;
        logic       vld;
        logic [7:0] half;
        logic       e_clk;
        logic       e_tick;
        logic       e_rdy;
        logic       e_err;
        logic [7:0] e_cur;
    } vec_t;

    vec_t tbl[$];

    tick_rate_controller #(.DIV_W(DIV_W), .DEFAULT_HALF(4)) dut (
        .clk_in    (clk_in),
        .resetf    (resetf),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .cur_half  (cur_half)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic vec_t mk(input logic en, input logic vld, input logic [7:0] half,
                                input logic e_clk, input logic e_tick, input logic e_rdy,
                                input logic e_err, input logic [7:0] e_cur);
        vec_t v;
        v.en = en; v.vld = vld; v.half = half;
        v.e_clk = e_clk; v.e_tick = e_tick; v.e_rdy = e_rdy; v.e_err = e_err; v.e_cur = e_cur;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic vld, input logic [7:0] half);
        enable    = en;
        cfg_valid = vld;
        cfg_half  = half;
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic e_clk, input logic e_tick,
                           input logic e_rdy, input logic e_err, input logic [7:0] e_cur);
        chk({nm, " clk_out"},   32'(clk_out),   32'(e_clk));
        chk({nm, " tick"},      32'(tick),      32'(e_tick));
        chk({nm, " cfg_ready"}, 32'(cfg_ready), 32'(e_rdy));
        chk({nm, " cfg_err"},   32'(cfg_err),   32'(e_err));
        chk({nm, " cur_half"},  32'(cur_half),  32'(e_cur));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = '0;
        resetf    = 1'b0;

        // Rows: en vld half | clk tick rdy err cur
        // Half 4 with a zero config rejected mid-high-phase
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4));  // 0  IDLE->RUN
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4));  // 1
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4));  // 2
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4));  // 3
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 4));  // 4  rise
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 1, 4));  // 5  zero config
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 4));  // 6
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 4));  // 7
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4));  // 8  fall
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4));  // 9
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4));  // 10
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4));  // 11
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 4));  // 12 rise
        // Switch to half 2 offered in the high phase
        tbl.push_back(mk(1, 1, 2, 1, 0, 0, 0, 4));  // 13 -> PEND
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 4));  // 14
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 4));  // 15
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2));  // 16 switch
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2));  // 17
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 2));  // 18
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 2));  // 19
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2));  // 20
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2));  // 21
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 2));  // 22
        // Switch to half 1
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 2));  // 23 -> PEND
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1));  // 24 switch
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 1));  // 25
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1));  // 26
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 1));  // 27
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1));  // 28
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 1));  // 29
        // Stop, load half 3 from IDLE, restart
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1));  // 30 -> IDLE
        tbl.push_back(mk(0, 1, 3, 0, 0, 1, 0, 3));  // 31 load in IDLE
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 3));  // 32
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 3));  // 33 -> RUN
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 3));  // 34
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 3));  // 35
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 3));  // 36 rise
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 3));  // 37
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 3));  // 38
        // Config accepted on a falling wrap waits a full period
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 3));  // 39 accept on fall
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3));  // 40
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3));  // 41
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 3));  // 42 rise, no switch
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 3));  // 43
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 3));  // 44
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2));  // 45 switch
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2));  // 46

        // Asynchronous reset before any clock edge
        #2;
        resetf = 1'b1;
        #1;
        chk_all("reset", 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        resetf = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].vld, tbl[i].half);
            chk_all($sformatf("row%0d", i), tbl[i].e_clk, tbl[i].e_tick,
                    tbl[i].e_rdy, tbl[i].e_err, tbl[i].e_cur);
        end

        // PEND with enable dropped: pending value applies immediately, go IDLE
        step(1, 1, 5);
        chk_all("pend_enter", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
        step(0, 0, 0);
        chk_all("pend_drop", 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);

        // Asynchronous reset between edges while in PEND with clk_out high
        step(1, 0, 0);                       // RUN, counter 0
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(1, 1, 7);                       // wrap: rise, accept -> PEND
        chk_all("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
        step(1, 0, 0);
        chk_all("pre_rst2", 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        #3;
        resetf = 1'b1;
        #1;
        chk_all("mid_rst", 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        @(negedge clk_in);
        resetf = 1'b0;

        // After release: behaves as from power-up, pending 7 never applied
        step(1, 0, 0);
        chk_all("post0", 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        for (int i = 1; i < 12; i++) begin
            step(1, 0, 0);
            chk_all($sformatf("post%0d", i),
                    ((i >= 4) && (i < 8)) ? 1'b1 : 1'b0,
                    (i == 4) ? 1'b1 : 1'b0,
                    1'b1, 1'b0, 8'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
